// File: rtl/nx_stream_pkg.sv
// Shared types for the stream arbiter: arbitration mode encoding and direction tag.
package nx_stream_pkg;

   typedef enum logic [0:0] {
      NX_ARB_RR    = 1'b0,
      NX_ARB_FIXED = 1'b1
   } nx_arb_mode_e;

   typedef logic [1:0] nx_dir_t;

endpackage

// File: rtl/nx_rr_arbiter.sv
// Combinational grant selection. Round-robin searches from ptr+1 with wrap.
// Fixed mode always searches from index 0.
module nx_rr_arbiter
   import nx_stream_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   input  nx_arb_mode_e    mode,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] idx,
   output logic            found
);

   int              start;
   int              cand;
   logic [IDXW-1:0] cand_idx;

   always_comb begin
      grant    = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // The modulo keeps the wrap correct when N is not a power of two.
      start    = (mode == NX_ARB_FIXED) ? 0 : (int'(ptr) + 1) % N;
      for (int i = 0; i < N; i++) begin
         cand     = (start + i) % N;
         cand_idx = IDXW'(cand);
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            idx             = cand_idx;
            grant[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nx_stream_arbiter.sv
// N-to-1 stream arbiter feeding a 2-entry output buffer.
// Ready is derived from registered occupancy only, so there is no path from comb_ready_i.
module nx_stream_arbiter
   import nx_stream_pkg::*;
#(
   parameter int           STREAM_WIDTH = 32,
   parameter int           INPUTS       = 4,
   parameter nx_arb_mode_e ARB_MODE     = NX_ARB_RR
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [INPUTS-1:0][STREAM_WIDTH-1:0]   stream_data_i,
   input  logic [INPUTS-1:0][1:0]                stream_dir_i,
   input  logic [INPUTS-1:0]                     stream_valid_i,
   output logic [INPUTS-1:0]                     stream_ready_o,
   output logic [STREAM_WIDTH-1:0]               comb_data_o,
   output logic [1:0]                            comb_dir_o,
   output logic [$clog2(INPUTS)-1:0]             comb_src_o,
   output logic                                  comb_valid_o,
   input  logic                                  comb_ready_i
);

   localparam int              SRCW       = $clog2(INPUTS);
   localparam logic [SRCW-1:0] LAST_RESET = SRCW'(INPUTS - 1);

   logic [STREAM_WIDTH-1:0] data_reg [2];
   logic [STREAM_WIDTH-1:0] data_next [2];
   nx_dir_t                 dir_reg [2];
   nx_dir_t                 dir_next [2];
   logic [SRCW-1:0]         src_reg [2];
   logic [SRCW-1:0]         src_next [2];
   logic [1:0]              occ_reg, occ_next;
   logic [SRCW-1:0]         last_grant_reg, last_grant_next;

   logic [INPUTS-1:0] grant;
   logic [SRCW-1:0]   grant_idx;
   logic              grant_found;
   logic              can_accept;
   logic              push;
   logic              pop;
   logic              wr_pos;

   nx_rr_arbiter #(
      .N    (INPUTS),
      .IDXW (SRCW)
   ) u_arb (
      .req   (stream_valid_i),
      .ptr   (last_grant_reg),
      .mode  (ARB_MODE),
      .grant (grant),
      .idx   (grant_idx),
      .found (grant_found)
   );

   // Gating with rst_ni keeps ready low while reset is held, when occupancy already reads 0.
   assign can_accept     = rst_ni && (occ_reg != 2'd2);
   assign stream_ready_o = can_accept ? grant : '0;
   assign push           = can_accept && grant_found;
   assign pop            = (occ_reg != 2'd0) && comb_ready_i;

   assign comb_valid_o = (occ_reg != 2'd0);
   assign comb_data_o  = data_reg[0];
   assign comb_dir_o   = dir_reg[0];
   assign comb_src_o   = src_reg[0];

   always_comb begin
      data_next       = data_reg;
      dir_next        = dir_reg;
      src_next        = src_reg;
      occ_next        = occ_reg + 2'(push) - 2'(pop);
      last_grant_next = last_grant_reg;
      wr_pos          = (occ_reg == 2'd1) && !pop;
      if (pop) begin
         data_next[0] = data_reg[1];
         dir_next[0]  = dir_reg[1];
         src_next[0]  = src_reg[1];
      end
      // Slot 0 is the head; a new beat lands behind whatever survives this cycle's pop.
      if (push) begin
         data_next[wr_pos] = stream_data_i[grant_idx];
         dir_next[wr_pos]  = stream_dir_i[grant_idx];
         src_next[wr_pos]  = grant_idx;
         last_grant_next   = grant_idx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occ_reg        <= '0;
         last_grant_reg <= LAST_RESET;
         data_reg       <= '{default: '0};
         dir_reg        <= '{default: '0};
         src_reg        <= '{default: '0};
      end else begin
         occ_reg        <= occ_next;
         last_grant_reg <= last_grant_next;
         data_reg       <= data_next;
         dir_reg        <= dir_next;
         src_reg        <= src_next;
      end
   end

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Bench for nx_stream_arbiter: RR and fixed 4-input instances plus a 3-input RR instance.
// Accepted beats go into a scoreboard queue and are compared when they leave the buffer.
module tb_nx_stream_arbiter;
   import nx_stream_pkg::*;

   typedef struct packed {
      logic [1:0]  src;
      logic [31:0] data;
      logic [1:0]  dir;
   } beat_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [3:0][31:0] a_data;
   logic [3:0][1:0]  a_dir;
   logic [3:0]       a_valid, a_ready;
   logic [31:0]      a_cdata;
   logic [1:0]       a_cdir, a_csrc;
   logic             a_cvalid, a_cready;

   logic [3:0][31:0] b_data;
   logic [3:0][1:0]  b_dir;
   logic [3:0]       b_valid, b_ready;
   logic [31:0]      b_cdata;
   logic [1:0]       b_cdir, b_csrc;
   logic             b_cvalid, b_cready;

   logic [2:0][31:0] c_data;
   logic [2:0][1:0]  c_dir;
   logic [2:0]       c_valid, c_ready;
   logic [31:0]      c_cdata;
   logic [1:0]       c_cdir, c_csrc;
   logic             c_cvalid, c_cready;

   beat_t      sb_q[$];
   logic [1:0] lg_model;
   logic       held_vld;
   beat_t      held_beat;

   logic [2:0] c_v_tbl [6] = '{3'b100, 3'b001, 3'b111, 3'b111, 3'b111, 3'b000};
   logic [2:0] c_r_tbl [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
   logic [1:0] c_s_tbl [6] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

   nx_stream_arbiter #(.STREAM_WIDTH(32), .INPUTS(4), .ARB_MODE(NX_ARB_RR)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .stream_data_i(a_data), .stream_dir_i(a_dir),
      .stream_valid_i(a_valid), .stream_ready_o(a_ready), .comb_data_o(a_cdata),
      .comb_dir_o(a_cdir), .comb_src_o(a_csrc), .comb_valid_o(a_cvalid), .comb_ready_i(a_cready)
   );

   nx_stream_arbiter #(.STREAM_WIDTH(32), .INPUTS(4), .ARB_MODE(NX_ARB_FIXED)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .stream_data_i(b_data), .stream_dir_i(b_dir),
      .stream_valid_i(b_valid), .stream_ready_o(b_ready), .comb_data_o(b_cdata),
      .comb_dir_o(b_cdir), .comb_src_o(b_csrc), .comb_valid_o(b_cvalid), .comb_ready_i(b_cready)
   );

   nx_stream_arbiter #(.STREAM_WIDTH(32), .INPUTS(3), .ARB_MODE(NX_ARB_RR)) dut_c (
      .clk_i(clk), .rst_ni(rst_n), .stream_data_i(c_data), .stream_dir_i(c_dir),
      .stream_valid_i(c_valid), .stream_ready_o(c_ready), .comb_data_o(c_cdata),
      .comb_dir_o(c_cdir), .comb_src_o(c_csrc), .comb_valid_o(c_cvalid), .comb_ready_i(c_cready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference round-robin choice for the 4-input instance given bench-tracked occupancy.
   function automatic logic [3:0] rr_expect(input logic [3:0] v, input logic [1:0] lg, input int occ);
      logic [3:0] r;
      logic [1:0] s;
      r = '0;
      if (occ < 2) begin
         for (int k = 1; k <= 4; k++) begin
            s = lg + 2'(k);
            if (v[s] && r == 4'd0) r[s] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      a_valid  = '0;
      b_valid  = '0;
      c_valid  = '0;
      a_cready = 1'b0;
      sb_q.delete();
      held_vld = 1'b0;
      lg_model = 2'd3;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle on instance A; exp_ready / exp_cv of -1 mean no table expectation.
   task automatic step_a(input logic [3:0] v, input logic rdy, input int exp_ready, input int exp_cv);
      logic [3:0] r;
      beat_t      got;
      beat_t      exp;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         a_data[i] = {2'(i), 30'(cyc)};
         a_dir[i]  = 2'(i) ^ 2'(cyc);
      end
      a_valid  = v;
      a_cready = rdy;
      #1;
      r = a_ready;
      check_eq("ready_model", r, rr_expect(v, lg_model, sb_q.size()));
      check_eq("ready_subset", r & ~v, 0);
      check_eq("cvalid_occ", a_cvalid, sb_q.size() != 0);
      if (exp_ready >= 0) check_eq("ready_tbl", r, 64'(exp_ready));
      if (exp_cv >= 0) check_eq("cvalid_tbl", a_cvalid, 64'(exp_cv));
      if (held_vld) check_eq("hold", {a_csrc, a_cdata, a_cdir}, held_beat);
      a_cready = ~rdy;
      #1;
      check_eq("comb_path", a_ready, r);
      a_cready = rdy;
      #1;
      if (a_cvalid && rdy) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", a_cvalid, 0);
         end else begin
            exp = sb_q.pop_front();
            got = {a_csrc, a_cdata, a_cdir};
            check_eq("beat", got, exp);
            $display("beat src=%0d data=%h dir=%0d", a_csrc, a_cdata, a_cdir);
         end
      end
      held_vld  = a_cvalid && !rdy;
      held_beat = {a_csrc, a_cdata, a_cdir};
      for (int i = 0; i < 4; i++) begin
         if (r[i] && v[i]) begin
            sb_q.push_back({2'(i), a_data[i], a_dir[i]});
            lg_model = 2'(i);
         end
      end
   endtask

   initial begin
      int b_occ;
      rst_n    = 1'b0;
      a_data   = '0;  a_dir = '0;  a_valid = 4'hF;  a_cready = 1'b1;
      b_data   = '0;  b_dir = '0;  b_valid = 4'hF;  b_cready = 1'b1;
      c_data   = '0;  c_dir = '0;  c_valid = 3'h7;  c_cready = 1'b1;
      sb_q.delete();
      held_vld = 1'b0;
      lg_model = 2'd3;

      // Held in reset across a clock edge with everything valid.
      #12;
      check_eq("rst_a_ready", a_ready, 0);
      check_eq("rst_a_cvalid", a_cvalid, 0);
      check_eq("rst_a_cdata", a_cdata, 0);
      check_eq("rst_a_csrc", a_csrc, 0);
      check_eq("rst_a_cdir", a_cdir, 0);
      check_eq("rst_b_ready", b_ready, 0);
      check_eq("rst_c_ready", c_ready, 0);
      check_eq("rst_c_cvalid", c_cvalid, 0);

      // Round-robin at full rate: sources 0,1,2,3,0,1,2,3 with no bubble.
      do_reset();
      for (int k = 0; k < 9; k++) step_a(4'hF, 1'b1, 1 << (k % 4), (k == 0) ? 0 : 1);
      check_eq("rr_count", sb_q.size(), 1);

      // Back-pressure: exactly two beats accepted, head holds, then drain 0,1.
      do_reset();
      step_a(4'hF, 1'b0, 1, 0);
      step_a(4'hF, 1'b0, 2, 1);
      repeat (4) step_a(4'hF, 1'b0, 0, 1);
      step_a(4'hF, 1'b1, 0, 1);
      step_a(4'h0, 1'b1, 0, 1);
      step_a(4'h0, 1'b1, 0, 0);
      check_eq("bp_drain", sb_q.size(), 0);

      // Asynchronous reset while full, then first grant goes to stream 0.
      do_reset();
      step_a(4'hF, 1'b0, 1, 0);
      step_a(4'hF, 1'b0, 2, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_cvalid", a_cvalid, 0);
      check_eq("arst_ready", a_ready, 0);
      check_eq("arst_cdata", a_cdata, 0);
      check_eq("arst_csrc", a_csrc, 0);
      sb_q.delete();
      held_vld = 1'b0;
      lg_model = 2'd3;
      a_valid  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step_a(4'hF, 1'b1, 1, 0);
      step_a(4'hF, 1'b1, 2, 1);

      // Fixed priority with streams 1 and 3 always valid.
      do_reset();
      b_occ = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         b_valid  = 4'b1010;
         b_cready = (k % 3) != 0;
         b_data[1] = 32'(k);
         b_data[3] = 32'(k + 100);
         #1;
         check_eq("fx_ready", b_ready, (b_occ == 2) ? 4'b0000 : 4'b0010);
         if (b_cvalid) begin
            check_eq("fx_src", b_csrc, 1);
            if (b_cready) $display("beat fx src=%0d data=%h", b_csrc, b_cdata);
         end
         b_occ = b_occ + (b_ready[1] ? 1 : 0) - ((b_cvalid && b_cready) ? 1 : 0);
      end
      b_valid = '0;

      // Three inputs: grant order 2,0 then 1,2,0 wrapping through index 2.
      do_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         c_valid  = (k < 6) ? c_v_tbl[k] : 3'b000;
         c_cready = 1'b1;
         for (int i = 0; i < 3; i++) c_data[i] = {2'(i), 30'(k)};
         #1;
         if (k < 6) check_eq("r3_ready", c_ready, c_r_tbl[k]);
         check_eq("r3_cvalid", c_cvalid, (k >= 1 && k <= 5) ? 1 : 0);
         if (k >= 1 && k <= 5) begin
            check_eq("r3_src", c_csrc, c_s_tbl[k]);
            check_eq("r3_data", c_cdata, {c_s_tbl[k], 30'(k - 1)});
            $display("beat r3 src=%0d data=%h", c_csrc, c_cdata);
         end
      end
      c_valid = '0;

      // Random valid/ready soak with scoreboard, then drain.
      do_reset();
      for (int k = 0; k < 10000; k++) step_a(4'($urandom), $urandom_range(0, 3) != 0, -1, -1);
      repeat (4) step_a(4'h0, 1'b1, -1, -1);
      check_eq("soak_drain", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
